// File: rtl/intr_ctrl_if.sv
// APB bus bundle between the CPU-side master and the interrupt controller.
interface intr_ctrl_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/intr_ctrl.sv
// APB-slave interrupt controller: pending latch, mask, fixed-priority encoder,
// registered CPU interrupt line and vector ID.
module intr_ctrl #(
  parameter int unsigned N_SRC   = 8,
  parameter logic [7:0]  RST_ITR = 8'hFF
) (
  input  logic             pclk,
  input  logic             presetn,
  intr_ctrl_if.slave       apb,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq,
  output logic [2:0]       irq_id
);

  // Bits at or above N_SRC are held at zero everywhere.
  localparam logic [7:0] VALID = 8'((9'd1 << N_SRC) - 9'd1);

  localparam logic [7:0] A_IER = 8'h00;
  localparam logic [7:0] A_IPR = 8'h01;
  localparam logic [7:0] A_ISR = 8'h02;
  localparam logic [7:0] A_IVR = 8'h03;
  localparam logic [7:0] A_ICR = 8'h04;
  localparam logic [7:0] A_ITR = 8'h05;

  logic [7:0] ier, ipr, itr, src_q, src_x;
  logic       gen;
  logic [7:0] act, set_v, w1c_v;
  logic       wr;
  logic [2:0] id_nxt;

  // Zero-extend the request inputs to the 8-bit register width.
  always_comb begin
    src_x = '0;
    src_x[N_SRC-1:0] = irq_src;
  end

  assign wr    = apb.psel & apb.penable & apb.pwrite;
  assign w1c_v = (wr && apb.paddr == A_IPR) ? apb.pwdata : '0;
  // Edge mode needs a fresh rise; level mode sets on every high sample.
  assign set_v = src_x & ~(itr & src_q) & VALID;
  assign act   = ipr & ier;

  // Register file, edge history and pending latch; a set beats a same-cycle W1C.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ier   <= '0;
      ipr   <= '0;
      itr   <= RST_ITR & VALID;
      gen   <= 1'b0;
      src_q <= '0;
    end else begin
      src_q <= src_x;
      ipr   <= ((ipr & ~w1c_v) | set_v) & VALID;
      if (wr) begin
        case (apb.paddr)
          A_IER:   ier <= apb.pwdata & VALID;
          A_ICR:   gen <= apb.pwdata[0];
          A_ITR:   itr <= apb.pwdata & VALID;
          default: ;
        endcase
      end
    end
  end

  // Fixed priority: scan from the top so the lowest set index is kept last.
  always_comb begin
    id_nxt = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (act[i-1]) id_nxt = 3'(i - 1);
    end
  end

  // Registered CPU interrupt outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      irq    <= gen & (|act);
      irq_id <= id_nxt;
    end
  end

  // Combinational read mux, active whenever a read is selected.
  always_comb begin
    apb.prdata = '0;
    if (apb.psel && !apb.pwrite) begin
      case (apb.paddr)
        A_IER:   apb.prdata = ier;
        A_IPR:   apb.prdata = ipr;
        A_ISR:   apb.prdata = act;
        A_IVR:   apb.prdata = {irq, 4'b0000, irq_id};
        A_ICR:   apb.prdata = {7'b0000000, gen};
        A_ITR:   apb.prdata = itr;
        default: apb.prdata = '0;
      endcase
    end
  end

  assign apb.pready  = 1'b1;
  assign apb.pslverr = apb.psel & apb.penable & (apb.paddr > A_ITR);

endmodule
